arm_btn_step_scheduler: RTL and testbench

Shares one button-driven step-rate timebase among the arm's joints: samples raw up/down buttons for each joint, arbitrates round-robin among joints with an active request, and issues one position step per timebase tick to the granted joint. Holds the per-joint position registers, saturated to the servo range, and feeds the servo PWM generators. When no button is held, the timebase is held cleared, so the first step after a press always takes one full step period.

---
 rtl/arm_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/arm_btn_step_scheduler.sv | 150 +++++++++++++++
 tb/tb_arm_btn_step_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the arm button step scheduler: FSM states, default
// parameters and the timebase counter width helper.
package arm_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int N_JOINTS_DEF    = 4;
    localparam int POS_W_DEF       = 8;
    localparam int POS_MIN_DEF     = 0;
    localparam int POS_MAX_DEF     = 180;
    localparam int POS_INIT_DEF    = 90;
    localparam int STEP_CYCLES_DEF = 390625;

    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester strictly after the one-hot
// last_served position, wrapping around; all-zero grant when nothing requests.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] last_served,
    output logic [N-1:0] grant
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] req_hi;
    logic [N-1:0] pick_hi;
    logic [N-1:0] pick_all;
    logic         seen;

    always_comb begin
        hi_mask = '0;
        seen    = 1'b0;
        for (int j = 0; j < N; j++) begin
            hi_mask[j] = seen;
            if (last_served[j]) begin
                seen = 1'b1;
            end
        end
    end

    assign req_hi = req & hi_mask;

    // Scan downwards so the lowest set bit is the one left standing.
    always_comb begin
        pick_hi  = '0;
        pick_all = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req_hi[j]) begin
                pick_hi    = '0;
                pick_hi[j] = 1'b1;
            end
            if (req[j]) begin
                pick_all    = '0;
                pick_all[j] = 1'b1;
            end
        end
    end

    assign grant = (req_hi != '0) ? pick_hi : pick_all;

endmodule

// File: rtl/arm_btn_step_scheduler.sv
// Shares one step-rate timebase among the arm joints: synchronizes buttons,
// grants joints round-robin and applies one saturated position step per tick.
//
// state | meaning
// IDLE  | no button request; timebase held at 0, nothing granted
// RUN   | timebase running; granted joint steps on terminal count
module arm_btn_step_scheduler
    import arm_pkg::*;
#(
    parameter int N_JOINTS    = N_JOINTS_DEF,
    parameter int POS_W       = POS_W_DEF,
    parameter int POS_MIN     = POS_MIN_DEF,
    parameter int POS_MAX     = POS_MAX_DEF,
    parameter int POS_INIT    = POS_INIT_DEF,
    parameter int STEP_CYCLES = STEP_CYCLES_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_JOINTS-1:0]       btn_up,
    input  logic [N_JOINTS-1:0]       btn_down,
    output logic [N_JOINTS*POS_W-1:0] pos,
    output logic [N_JOINTS-1:0]       grant,
    output logic                      busy,
    output logic                      step_pulse,
    output logic [N_JOINTS-1:0]       at_limit
);

    localparam int                  CW       = cnt_width(STEP_CYCLES);
    localparam logic [CW-1:0]       CNT_LAST = CW'(STEP_CYCLES - 1);
    localparam logic [POS_W-1:0]    P_MIN    = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0]    P_MAX    = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0]    P_INIT   = POS_W'(POS_INIT);
    localparam logic [N_JOINTS-1:0] LS_INIT  = {1'b1, {(N_JOINTS-1){1'b0}}};
    localparam logic                AT_INIT  = (POS_INIT == POS_MIN) || (POS_INIT == POS_MAX);
    localparam logic [0:0]          ST_IDLE  = IDLE;
    localparam logic [0:0]          ST_RUN   = RUN;

    logic [N_JOINTS-1:0] up_m, up_s, dn_m, dn_s;
    logic [N_JOINTS-1:0] req, dir;
    logic [N_JOINTS-1:0] last_served;
    logic [N_JOINTS-1:0] arb_ptr, next_grant;
    logic [POS_W-1:0]    pos_r [N_JOINTS];
    logic [CW-1:0]       cnt;
    logic [0:0]          state;
    logic                any_req, req_g, tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_m <= '0;
            up_s <= '0;
            dn_m <= '0;
            dn_s <= '0;
        end else begin
            up_m <= btn_up;
            up_s <= up_m;
            dn_m <= btn_down;
            dn_s <= dn_m;
        end
    end

    assign req     = up_s ^ dn_s;
    assign dir     = up_s;
    assign any_req = |req;
    assign req_g   = |(req & grant);
    assign tick    = (cnt == CNT_LAST);
    assign busy    = (state == ST_RUN);

    // While running the search starts after the current grant, which is also
    // what last_served becomes on a tick; from IDLE it resumes after last_served.
    assign arb_ptr = (state == ST_RUN) ? grant : last_served;

    rr_arbiter #(
        .N(N_JOINTS)
    ) u_arb (
        .req        (req),
        .last_served(arb_ptr),
        .grant      (next_grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            grant       <= '0;
            last_served <= LS_INIT;
            step_pulse  <= 1'b0;
            for (int j = 0; j < N_JOINTS; j++) begin
                pos_r[j] <= P_INIT;
            end
        end else begin
            step_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (any_req) begin
                        state <= ST_RUN;
                        grant <= next_grant;
                    end
                end
                ST_RUN: begin
                    if (!any_req) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        grant <= '0;
                    end else begin
                        cnt <= tick ? '0 : cnt + 1'b1;
                        if (!req_g) begin
                            grant <= next_grant;
                        end else if (tick) begin
                            last_served <= grant;
                            grant       <= next_grant;
                            for (int j = 0; j < N_JOINTS; j++) begin
                                if (grant[j]) begin
                                    if (dir[j]) begin
                                        if (pos_r[j] != P_MAX) begin
                                            pos_r[j]   <= pos_r[j] + 1'b1;
                                            step_pulse <= 1'b1;
                                        end
                                    end else if (pos_r[j] != P_MIN) begin
                                        pos_r[j]   <= pos_r[j] - 1'b1;
                                        step_pulse <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            at_limit <= {N_JOINTS{AT_INIT}};
        end else begin
            for (int j = 0; j < N_JOINTS; j++) begin
                at_limit[j] <= (pos_r[j] == P_MIN) || (pos_r[j] == P_MAX);
            end
        end
    end

    always_comb begin
        pos = '0;
        for (int j = 0; j < N_JOINTS; j++) begin
            pos[j*POS_W +: POS_W] = pos_r[j];
        end
    end

endmodule

// File: tb/tb_arm_btn_step_scheduler.sv
// Scoreboard bench for arm_btn_step_scheduler: directed scenarios plus random
// button traffic against a cycle-level reference model of the stepping rules.
module tb_arm_btn_step_scheduler;

    localparam int N     = 4;
    localparam int PW    = 8;
    localparam int PMIN  = 0;
    localparam int PMAX  = 180;
    localparam int PINIT = 90;
    localparam int STEP  = 4;
    localparam logic [N-1:0] ONE = 1;

    typedef struct {
        int j;
        int v;
    } step_t;

    logic            clk;
    logic            rst;
    logic [N-1:0]    btn_up;
    logic [N-1:0]    btn_down;
    logic [N*PW-1:0] pos;
    logic [N-1:0]    grant;
    logic            busy;
    logic            step_pulse;
    logic [N-1:0]    at_limit;

    arm_btn_step_scheduler #(
        .N_JOINTS   (N),
        .POS_W      (PW),
        .POS_MIN    (PMIN),
        .POS_MAX    (PMAX),
        .POS_INIT   (PINIT),
        .STEP_CYCLES(STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .pos       (pos),
        .grant     (grant),
        .busy      (busy),
        .step_pulse(step_pulse),
        .at_limit  (at_limit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [N-1:0] m_up1, m_up2, m_dn1, m_dn2;
    logic [N-1:0] m_atlim;
    int           m_pos [N];
    bit           m_active;
    int           m_phase;
    int           m_g;
    int           m_last;
    step_t        exp_q [$];
    step_t        mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bit_of(input logic [N-1:0] v, input int k);
        return |(v & (ONE << k));
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        if (k < 0) return '0;
        return ONE << k;
    endfunction

    function automatic int rr_next(input logic [N-1:0] r, input int from);
        for (int i = 1; i <= N; i++) begin
            if (bit_of(r, (from + i) % N)) return (from + i) % N;
        end
        return -1;
    endfunction

    function automatic int pos_of(input int j);
        return int'(pos[j*PW +: PW]);
    endfunction

    task automatic model_reset();
        m_up1 = '0; m_up2 = '0; m_dn1 = '0; m_dn2 = '0;
        m_active = 1'b0;
        m_phase  = 0;
        m_g      = -1;
        m_last   = N - 1;
        for (int j = 0; j < N; j++) begin
            m_pos[j]   = PINIT;
            m_atlim[j] = (PINIT == PMIN) || (PINIT == PMAX);
        end
        exp_q.delete();
    endtask

    // One clock edge of the stepping rules, using the pre-edge button values.
    task automatic model_step();
        logic [N-1:0] req, dirv;
        bit           tk;
        int           np;
        req  = m_up2 ^ m_dn2;
        dirv = m_up2;
        for (int j = 0; j < N; j++) m_atlim[j] = (m_pos[j] == PMIN) || (m_pos[j] == PMAX);
        if (!m_active) begin
            if (req != '0) begin
                m_active = 1'b1;
                m_phase  = 0;
                m_g      = rr_next(req, m_last);
            end
        end else if (req == '0) begin
            m_active = 1'b0;
            m_phase  = 0;
            m_g      = -1;
        end else begin
            tk      = (m_phase == STEP - 1);
            m_phase = (m_phase + 1) % STEP;
            if (!bit_of(req, m_g)) begin
                m_g = rr_next(req, m_g);
            end else if (tk) begin
                np = m_pos[m_g] + (bit_of(dirv, m_g) ? 1 : -1);
                if (np >= PMIN && np <= PMAX) begin
                    m_pos[m_g] = np;
                    exp_q.push_back('{m_g, np});
                end
                m_last = m_g;
                m_g    = rr_next(req, m_g);
            end
        end
        m_up2 = m_up1; m_dn2 = m_dn1;
        m_up1 = btn_up; m_dn1 = btn_down;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        btn_up   = '0;
        btn_down = '0;
        repeat (n) cyc();
    endtask

    // monitor: per-cycle outputs against the model, step events from the queue
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 32'(busy), 32'(m_active));
            chk("grant", 32'(grant), 32'(onehot(m_g)));
            chk("at_limit", 32'(at_limit), 32'(m_atlim));
            for (int j = 0; j < N; j++) chk("pos", 32'(pos_of(j)), 32'(m_pos[j]));
            if (step_pulse) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL step_pulse actual=1 required=0 at t=%0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("step_pos", 32'(pos_of(mon_e.j)), 32'(mon_e.v));
                end
            end else if (exp_q.size() != 0) begin
                total++; bad++;
                $display("FAIL step_pulse actual=0 required=1 at t=%0t", $time);
                exp_q.delete();
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_e, step_e, busy_cnt, guard;
        rst = 1'b1;
        btn_up = '0;
        btn_down = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc();

        // reset values
        for (int j = 0; j < N; j++) chk("reset_pos", 32'(pos_of(j)), 32'(PINIT));
        chk("reset_grant", 32'(grant), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_at_limit", 32'(at_limit), 0);

        // single joint, press-to-run latency and step cadence
        busy_e = -1; step_e = -1;
        btn_up = 4'b0001;
        for (int e = 1; e <= 30; e++) begin
            cyc();
            if (busy && busy_e < 0) busy_e = e;
            if (step_pulse && step_e < 0) step_e = e;
        end
        chk("busy_latency", 32'(busy_e), 3);
        chk("first_step", 32'(step_e), 7);
        chk("pos0_after_30", 32'(pos_of(0)), 96);
        chk("pos1_untouched", 32'(pos_of(1)), 90);
        idle(8);

        // two requesters sharing the timebase
        btn_up = 4'b0010; btn_down = 4'b0100;
        repeat (35) cyc();
        chk("pos1_shared", 32'(pos_of(1)), 94);
        chk("pos2_shared", 32'(pos_of(2)), 86);
        idle(8);

        // upper saturation on joint 3
        btn_up = 4'b1000;
        repeat (380) cyc();
        chk("pos3_sat", 32'(pos_of(3)), 180);
        chk("at_limit3", 32'(at_limit[3]), 1);
        idle(8);
        btn_down = 4'b1000;
        repeat (8) cyc();
        chk("pos3_down", 32'(pos_of(3)), 179);
        idle(8);

        // both buttons on one joint is no request
        busy_cnt = 0;
        btn_up = 4'b0001; btn_down = 4'b0001;
        repeat (20) begin
            cyc();
            if (busy) busy_cnt++;
        end
        chk("both_pressed_busy", 32'(busy_cnt), 0);
        idle(8);

        // release two cycles before a tick discards it
        btn_up = 4'b0010;
        repeat (11) cyc();
        idle(8);
        chk("pos1_discard", 32'(pos_of(1)), 96);
        busy_e = -1; step_e = -1;
        btn_up = 4'b0010;
        for (int e = 1; e <= 12; e++) begin
            cyc();
            if (busy && busy_e < 0) busy_e = e;
            if (step_pulse && step_e < 0) step_e = e;
        end
        chk("repress_first_step", 32'(step_e - busy_e), STEP);
        idle(8);

        // random button traffic
        for (int b = 0; b < 60; b++) begin
            btn_up   = N'($urandom_range(0, 15));
            btn_down = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
            repeat ($urandom_range(1, 12)) cyc();
        end
        idle(8);

        // walk joint 0 to 100 and reset while running
        guard = 0;
        while (!(m_pos[0] == 100 && m_active) && guard < 2000) begin
            btn_down = '0;
            btn_up   = '0;
            if (m_pos[0] < 100) btn_up[0] = 1'b1;
            else                btn_down[0] = 1'b1;
            cyc();
            guard++;
        end
        chk("walk_guard", 32'(guard < 2000), 1);
        chk("pos0_pre_reset", 32'(pos_of(0)), 100);
        #2;
        rst = 1'b1;
        btn_up = '0; btn_down = '0;
        model_reset();
        #1;
        chk("rst_pos0", 32'(pos_of(0)), 90);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_step_pulse", 32'(step_pulse), 0);
        chk("rst_at_limit", 32'(at_limit), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
